// File: rtl/hazard_control_unit_if.sv
// Hazard control bundle: ID/EX-stage hazard inputs from the pipeline and the
// stall/flush controls returned by the hazard unit.
interface hazard_control_unit_if #(
  parameter int STALL_COUNT_WIDTH = 16
);
  logic [31:0]                  id_instruction;
  logic [3:0]                   id_ex_rd;
  logic                         id_ex_reg_write;
  logic                         id_ex_mem_to_reg;
  logic                         pc_source_select;
  logic                         pc_enable;
  logic                         if_id_enable;
  logic                         nop_select;
  logic [1:0]                   hazard_state;
  logic [STALL_COUNT_WIDTH-1:0] stall_count;

  // Pipeline side: presents the instruction/EX state, consumes the controls.
  modport master (
    output id_instruction, id_ex_rd, id_ex_reg_write, id_ex_mem_to_reg, pc_source_select,
    input  pc_enable, if_id_enable, nop_select, hazard_state, stall_count
  );

  // Hazard unit side.
  modport slave (
    input  id_instruction, id_ex_rd, id_ex_reg_write, id_ex_mem_to_reg, pc_source_select,
    output pc_enable, if_id_enable, nop_select, hazard_state, stall_count
  );
endinterface

// File: rtl/hazard_control_unit.sv
// Load-use hazard detection and branch flush control for a 5-stage ARM-like
// pipeline. Stalls PC and IF/ID and inserts a bubble when the ID instruction
// reads the destination of a load in EX; squashes one wrong-path instruction
// after a taken branch; counts bubble cycles with saturation.
module hazard_control_unit #(
  parameter int STALL_COUNT_WIDTH = 16
) (
  input logic             clk,
  input logic             reset,
  hazard_control_unit_if.slave hz
);

  typedef enum logic [1:0] {
    RUN   = 2'b00,
    STALL = 2'b01,
    FLUSH = 2'b10
  } state_t;

  state_t                       state;
  state_t                       state_next;
  logic [STALL_COUNT_WIDTH-1:0] count;

  logic       use_rn;
  logic       use_rm;
  logic       use_rd;
  logic       hazard;
  logic       pc_en;
  logic       ifid_en;
  logic       nop;
  logic [3:0] opcode;

  assign opcode = hz.id_instruction[24:21];

  // Decode which register fields the ID instruction reads (condition ignored).
  always_comb begin
    use_rn = 1'b0;
    use_rm = 1'b0;
    use_rd = 1'b0;
    if (hz.id_instruction != '0) begin
      unique case (hz.id_instruction[27:26])
        2'b00: begin
          use_rn = !((opcode == 4'b1101) || (opcode == 4'b1111));
          use_rm = !hz.id_instruction[25];
        end
        2'b01: begin
          use_rn = 1'b1;
          use_rm = hz.id_instruction[25];
          use_rd = !hz.id_instruction[20];
        end
        default: ;
      endcase
    end
  end

  // Load-use hazard: a load in EX writes a register the ID instruction reads.
  always_comb begin
    hazard = hz.id_ex_mem_to_reg && hz.id_ex_reg_write &&
             ((use_rn && (hz.id_instruction[19:16] == hz.id_ex_rd)) ||
              (use_rm && (hz.id_instruction[3:0]   == hz.id_ex_rd)) ||
              (use_rd && (hz.id_instruction[15:12] == hz.id_ex_rd)));
  end

  // Next-state and pipeline controls; reset forces the free-running defaults.
  always_comb begin
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    nop        = 1'b0;
    state_next = RUN;
    if (!reset) begin
      unique case (state)
        RUN, STALL: begin
          if (hazard) begin
            pc_en      = 1'b0;
            ifid_en    = 1'b0;
            nop        = 1'b1;
            state_next = STALL;
          end else if (hz.pc_source_select) begin
            state_next = FLUSH;
          end
        end
        FLUSH: begin
          nop = 1'b1;
        end
        default: ;
      endcase
    end
  end

  // State register and saturating bubble counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= RUN;
      count <= '0;
    end else begin
      state <= state_next;
      if (nop && (count != '1)) begin
        count <= count + STALL_COUNT_WIDTH'(1);
      end
    end
  end

  assign hz.pc_enable    = pc_en;
  assign hz.if_id_enable = ifid_en;
  assign hz.nop_select   = nop;
  assign hz.hazard_state = state;
  assign hz.stall_count  = count;

endmodule
